// File: rtl/sisc_ifetch_if.sv
// sisc_ifetch_if: fetch-stage bus bundle.
// Carries the imem req/ack, ir valid/ready and control redirects.
interface sisc_ifetch_if #(
   parameter int ADDR_W = 16
);
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ack;
   logic [31:0]       imem_rdata;
   logic [31:0]       ir;
   logic [ADDR_W-1:0] ir_pc;
   logic              ir_valid;
   logic              ir_ready;
   logic              br_taken;
   logic [ADDR_W-1:0] br_addr;
   logic              halt;
   logic              halted;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata,
      output ir,
      output ir_pc,
      output ir_valid,
      input  ir_ready,
      input  br_taken,
      input  br_addr,
      input  halt,
      output halted
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata,
      input  ir,
      input  ir_pc,
      input  ir_valid,
      output ir_ready,
      output br_taken,
      output br_addr,
      output halt,
      input  halted
   );
endinterface

// File: rtl/sisc_ifetch.sv
// sisc_ifetch: instruction fetch stage feeding the SISC core ir input.
// Optional fetch counter port enabled by defining IFETCH_CNT_EN.
module sisc_ifetch #(
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic         clk,
   input  logic         rst_f,
`ifdef IFETCH_CNT_EN
   output logic [31:0]  fetch_cnt,
`endif
   sisc_ifetch_if.master bus
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      HOLD,
      HALT
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] fetch_pc;
   logic              req_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       ir_q;
   logic [ADDR_W-1:0] ir_pc_q;
   logic              valid_q;
   logic              halted_q;
   logic              take;

   // an ack only counts while our own request is on the bus
   assign take = (state == REQ) && req_q && bus.imem_ack;

   assign bus.imem_req  = req_q;
   assign bus.imem_addr = addr_q;
   assign bus.ir        = ir_q;
   assign bus.ir_pc     = ir_pc_q;
   assign bus.ir_valid  = valid_q;
   assign bus.halted    = halted_q;

   // fetch FSM with registered bus and ir outputs
   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         state    <= IDLE;
         fetch_pc <= RESET_PC;
         req_q    <= 1'b0;
         addr_q   <= RESET_PC;
         ir_q     <= 32'h0;
         ir_pc_q  <= '0;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               state  <= REQ;
               addr_q <= fetch_pc;
            end
            REQ: begin
               if (!req_q) begin
                  req_q  <= 1'b1;
                  addr_q <= fetch_pc;
               end else if (take) begin
                  ir_q     <= bus.imem_rdata;
                  ir_pc_q  <= fetch_pc;
                  valid_q  <= 1'b1;
                  fetch_pc <= fetch_pc + 1'b1;
                  req_q    <= 1'b0;
                  state    <= HOLD;
               end
            end
            HOLD: begin
               if (bus.ir_ready) begin
                  valid_q <= 1'b0;
                  if (bus.halt) begin
                     state    <= HALT;
                     halted_q <= 1'b1;
                  end else if (bus.br_taken) begin
                     fetch_pc <= bus.br_addr;
                     addr_q   <= bus.br_addr;
                     state    <= REQ;
                  end else begin
                     addr_q <= fetch_pc;
                     state  <= REQ;
                  end
               end
            end
            HALT: begin
               state <= HALT;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef IFETCH_CNT_EN
   // saturating count of accepted memory responses
   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         fetch_cnt <= 32'h0;
      end else if (take && fetch_cnt != 32'hFFFF_FFFF) begin
         fetch_cnt <= fetch_cnt + 32'd1;
      end
   end
`endif

endmodule
